// File: rtl/lsu_arb.sv
// Two-master arbiter in front of the LSU memory port: fixed priority to port 0,
// starvation-forced and lock-burst grants for port 1, registered load response.
module lsu_arb #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_bmask,
    input  logic [2:0]  m0_ldsel,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_bmask,
    input  logic [2:0]  m1_ldsel,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] rdata,
    output logic [15:0] lsu_addr,
    output logic [31:0] lsu_wdata,
    output logic        lsu_wr_en,
    output logic [3:0]  lsu_bmask,
    output logic [2:0]  lsu_ldsel,
    input  logic [31:0] lsu_rdata
);

    localparam int unsigned CNT_W      = 4;
    localparam logic [2:0]  LDSEL_IDLE = 3'b010;

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_act;

    logic force1;
    logic lock1;
    logic lock_act_d;
    logic load_gnt;

    // Grant selection: forced port 1, locked port 1, then port 0, then port 1
    always_comb begin
        force1 = m1_req && (wait_cnt == CNT_W'(MAX_WAIT));
        lock1  = lock_act && m1_req && !(m0_req && (lock_cnt == CNT_W'(MAX_LOCK)));
        m1_gnt = m1_req && (force1 || lock1 || !m0_req);
        m0_gnt = m0_req && !m1_gnt;
        lock_act_d = m1_gnt && m1_lock;
    end

    // LSU mux; idle drives a harmless word load of address 0
    always_comb begin
        lsu_addr  = '0;
        lsu_wdata = '0;
        lsu_bmask = '0;
        lsu_ldsel = LDSEL_IDLE;
        lsu_wr_en = 1'b0;
        load_gnt  = 1'b0;
        if (m0_gnt) begin
            lsu_addr  = m0_addr;
            lsu_wdata = m0_wdata;
            lsu_bmask = m0_bmask;
            lsu_ldsel = m0_ldsel;
            lsu_wr_en = m0_we && rst_n;
            load_gnt  = !m0_we;
        end else if (m1_gnt) begin
            lsu_addr  = m1_addr;
            lsu_wdata = m1_wdata;
            lsu_bmask = m1_bmask;
            lsu_ldsel = m1_ldsel;
            lsu_wr_en = m1_we && rst_n;
            load_gnt  = !m1_we;
        end
    end

    // Starvation and lock-burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            lock_cnt <= '0;
            lock_act <= 1'b0;
        end else begin
            lock_act <= lock_act_d;

            if (!m1_req || m1_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (m0_gnt || (lock_act && !lock_act_d)) begin
                lock_cnt <= '0;
            end else if (m1_gnt && m0_req && (lock_cnt != CNT_W'(MAX_LOCK))) begin
                lock_cnt <= lock_cnt + CNT_W'(1);
            end
        end
    end

    // Load response: data held between loads, valid pulses for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt && load_gnt;
            m1_rvalid <= m1_gnt && load_gnt;
            if (load_gnt) begin
                rdata <= lsu_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_arb.sv
// Bench for lsu_arb: directed scenarios followed by randomized traffic, each cycle
// compared against a rule-level reference model of the arbiter.
module tb_lsu_arb;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned MAX_LOCK = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_bmask, m1_bmask;
    logic [2:0]  m0_ldsel, m1_ldsel;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] rdata;
    logic [15:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_wr_en;
    logic [3:0]  lsu_bmask;
    logic [2:0]  lsu_ldsel;
    logic [31:0] lsu_rdata;

    logic        use_fixed;
    logic [31:0] fixed_rd;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int   mw, ml;
    bit   mla;
    bit   mrv0, mrv1;
    logic [31:0] mrd;
    bit   e0, e1;

    lsu_arb #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_bmask(m0_bmask), .m0_ldsel(m0_ldsel),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_bmask(m1_bmask), .m1_ldsel(m1_ldsel), .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wr_en(lsu_wr_en),
        .lsu_bmask(lsu_bmask), .lsu_ldsel(lsu_ldsel), .lsu_rdata(lsu_rdata)
    );

    always #5 clk = ~clk;

    // memory stand-in: read data derived from the presented address
    always_comb lsu_rdata = use_fixed ? fixed_rd : {lsu_addr ^ 16'h5A5A, lsu_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mw = 0; ml = 0; mla = 0; mrv0 = 0; mrv1 = 0; mrd = '0;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_bmask = '0; m0_ldsel = 3'b010;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_bmask = '0; m1_ldsel = 3'b010;
        m1_lock = 0;
    endtask

    // One clock cycle: check grant/LSU outputs mid-cycle, then response after the edge
    task automatic step();
        logic [15:0] ea;
        logic [31:0] ewd, erd;
        logic [3:0]  ebm;
        logic [2:0]  els;
        logic        ewe;
        bit          f1, l1, nla;
        if (!rst_n) model_reset();
        f1 = m1_req && (mw == int'(MAX_WAIT));
        l1 = mla && m1_req && !(m0_req && (ml == int'(MAX_LOCK)));
        e1 = m1_req && (f1 || l1 || !m0_req);
        e0 = m0_req && !e1;
        ea = '0; ewd = '0; ebm = '0; els = 3'b010; ewe = 0;
        if (e0) begin
            ea = m0_addr; ewd = m0_wdata; ebm = m0_bmask; els = m0_ldsel; ewe = m0_we;
        end else if (e1) begin
            ea = m1_addr; ewd = m1_wdata; ebm = m1_bmask; els = m1_ldsel; ewe = m1_we;
        end
        erd = use_fixed ? fixed_rd : {ea ^ 16'h5A5A, ea};
        #1;
        chk("m0_gnt", 32'(m0_gnt), 32'(e0));
        chk("m1_gnt", 32'(m1_gnt), 32'(e1));
        chk("lsu_addr", 32'(lsu_addr), 32'(ea));
        chk("lsu_wdata", lsu_wdata, ewd);
        chk("lsu_bmask", 32'(lsu_bmask), 32'(ebm));
        chk("lsu_ldsel", 32'(lsu_ldsel), 32'(els));
        chk("lsu_wr_en", 32'(lsu_wr_en), 32'(ewe && rst_n));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            mrv0 = e0 && !ewe;
            mrv1 = e1 && !ewe;
            if ((e0 || e1) && !ewe) mrd = erd;
            nla = e1 && m1_lock;
            if (!m1_req || e1) mw = 0;
            else if (mw < int'(MAX_WAIT)) mw = mw + 1;
            if (e0 || (mla && !nla)) ml = 0;
            else if (e1 && m0_req && ml < int'(MAX_LOCK)) ml = ml + 1;
            mla = nla;
        end
        #1;
        chk("m0_rvalid", 32'(m0_rvalid), 32'(mrv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(mrv1));
        chk("rdata", rdata, mrd);
    endtask

    task automatic new_m0();
        m0_req = ($urandom_range(3) != 0);
        m0_we = 1'($urandom_range(1)); m0_addr = 16'($urandom); m0_wdata = $urandom;
        m0_bmask = 4'($urandom); m0_ldsel = 3'($urandom_range(5));
    endtask

    task automatic new_m1();
        m1_req = ($urandom_range(1) != 0);
        m1_we = 1'($urandom_range(1)); m1_addr = 16'($urandom); m1_wdata = $urandom;
        m1_bmask = 4'($urandom); m1_ldsel = 3'($urandom_range(5));
    endtask

    initial begin
        use_fixed = 0; fixed_rd = '0;
        idle_inputs();
        model_reset();
        rst_n = 0;
        #12;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("reset_m1_rvalid", 32'(m1_rvalid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;

        // port 0 load, fixed read data
        use_fixed = 1; fixed_rd = 32'hDEADBEEF;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010; m0_ldsel = 3'b010;
        step();
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_m0_rvalid", 32'(m0_rvalid), 32'h1);
        m0_req = 0;
        step();
        use_fixed = 0;

        // starvation: m1 forced at cycle MAX_WAIT
        m0_req = 1; m0_addr = 16'h0100; m1_req = 1; m1_we = 0; m1_addr = 16'h0200;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t2_m1_gnt", 32'(e1), (c == 4) ? 32'h1 : 32'h0);
            if (c == 4) m1_req = 0;
        end
        m0_req = 0;
        step();

        // locked store burst against a busy port 0
        m0_req = 1; m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 16'h8000; m1_wdata = 32'h1234_5678;
        m1_bmask = 4'hF;
        for (int c = 0; c < 13; c++) begin
            step();
            chk("t3_m1_gnt", 32'(e1), (c >= 4 && c <= 11) ? 32'h1 : 32'h0);
        end
        m1_req = 0; m1_lock = 0;
        step();
        chk("t3_m0_after", 32'(e0), 32'h1);
        idle_inputs();
        step();

        // simultaneous port 0 store and port 1 load
        m0_req = 1; m0_we = 1; m0_addr = 16'h4000; m0_wdata = 32'h0000_00A5; m0_bmask = 4'b0001;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0044;
        step();
        chk("t4_wr_en", 32'(e0 && m0_we), 32'h1);
        m0_req = 0;
        step();
        chk("t4_m1_rvalid", 32'(m1_rvalid), 32'h1);
        m1_req = 0;
        step();

        // reset in the middle of a load response with a store pending
        m0_req = 1; m0_we = 0; m0_addr = 16'h0020;
        step();
        m0_we = 1; m0_addr = 16'h4004;
        #1;
        rst_n = 0;
        #1;
        chk("t5_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("t5_rdata", rdata, 32'h0);
        chk("t5_wr_en", 32'(lsu_wr_en), 32'h0);
        chk("t5_gnt", 32'(m0_gnt), 32'h1);
        @(posedge clk); #1;
        chk("t5_wr_en_edge", 32'(lsu_wr_en), 32'h0);
        model_reset();
        step();
        rst_n = 1;
        m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 16'h0300;
        step();
        chk("t5_first_gnt", 32'(m1_gnt), 32'h1);
        idle_inputs();
        step();

        // randomized traffic with occasional resets
        new_m0(); new_m1();
        for (int c = 0; c < 600; c++) begin
            m1_lock = ($urandom_range(2) != 0);
            rst_n = ($urandom_range(99) != 0);
            step();
            if (e0 || !m0_req || !rst_n) new_m0();
            if (e1 || !m1_req || !rst_n) new_m1();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
